rx_fifo: RTL and testbench



---
 rtl/rx_fifo.sv | 90 +++++++++
 tb/tb_rx_fifo.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo.sv
// Receive byte FIFO behind the UART receiver: captures a byte on each RDA
// rising edge and presents it first-word-fall-through with a pop handshake.
module rx_fifo #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        RxD_data,
    input  logic              RDA,
    input  logic              rd_en,
    input  logic              clr_ovr,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overrun
);

    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              ovr_q, ovr_d;
    logic              rda_q, rda_d;

    logic push, pop, accept, drop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign overrun = ovr_q;
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    // A capture is the 0->1 transition of RDA, not its level.
    assign push   = RDA & ~rda_q;
    assign pop    = rd_en & ~empty;
    assign accept = push & (~full | pop);
    assign drop   = push & full & ~pop;

    always_comb begin
        rda_d    = RDA;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovr_d    = ovr_q;
        if (accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + (ADDR_W+1)'(1);
            2'b01:   count_d = count_q - (ADDR_W+1)'(1);
            default: count_d = count_q;
        endcase
        // A dropped byte outranks a simultaneous clear.
        if (drop) begin
            ovr_d = 1'b1;
        end else if (clr_ovr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovr_q    <= 1'b0;
            rda_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovr_q    <= ovr_d;
            rda_q    <= rda_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= RxD_data;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// Bench for rx_fifo: per-cycle vector table plus scoreboard-driven
// sequences for fill, overrun, wrap, simultaneous push/pop and reset.
module tb_rx_fifo;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              clk;
    logic              rst;
    logic [7:0]        RxD_data;
    logic              RDA;
    logic              rd_en;
    logic              clr_ovr;
    logic [7:0]        rd_data;
    logic              empty;
    logic              full;
    logic [ADDR_W:0]   count;
    logic              overrun;

    rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .RxD_data(RxD_data), .RDA(RDA),
        .rd_en(rd_en), .clr_ovr(clr_ovr), .rd_data(rd_data),
        .empty(empty), .full(full), .count(count), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rda;
        logic [7:0] data;
        logic       rd;
        logic       clr;
        int         e_cnt;
        logic       e_emp;
        logic       e_full;
        logic       e_ovr;
        logic [7:0] e_rd;
    } vec_t;

    vec_t vecs [10];

    int total = 0;
    int bad   = 0;

    logic [7:0] sb [$];
    int         m_cnt;
    logic       m_ovr;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] head;
        head = (sb.size() > 0) ? sb[0] : 8'h00;
        chk({tag, " count"}, 32'(count), 32'(m_cnt));
        chk({tag, " empty"}, 32'(empty), 32'(m_cnt == 0));
        chk({tag, " full"}, 32'(full), 32'(m_cnt == DEPTH));
        chk({tag, " overrun"}, 32'(overrun), 32'(m_ovr));
        chk({tag, " rd_data"}, 32'(rd_data), 32'(head));
    endtask

    task automatic push_byte(input logic [7:0] b, input logic with_pop,
                             input logic clr, input int low_cycles);
        logic do_pop;
        logic acc;
        RDA = 1'b0;
        rd_en = 1'b0;
        clr_ovr = 1'b0;
        for (int i = 0; i < low_cycles; i++) tick();
        RxD_data = b;
        RDA = 1'b1;
        rd_en = with_pop;
        clr_ovr = clr;
        do_pop = with_pop && (m_cnt > 0);
        acc = (m_cnt < DEPTH) || do_pop;
        if (do_pop) void'(sb.pop_front());
        if (acc) sb.push_back(b);
        if (acc && !do_pop) m_cnt++;
        if (!acc && do_pop) m_cnt--;
        if (!acc) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        tick();
        rd_en = 1'b0;
        clr_ovr = 1'b0;
        check_model("push");
    endtask

    task automatic pop_byte(input logic [7:0] exp_b);
        chk("pop head", 32'(rd_data), 32'(exp_b));
        rd_en = 1'b1;
        if (m_cnt > 0) begin
            void'(sb.pop_front());
            m_cnt--;
        end
        tick();
        rd_en = 1'b0;
        check_model("pop");
    endtask

    task automatic do_reset();
        rst = 1'b1;
        RDA = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_ovr = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b0, 8'hA5, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b1, 8'hA5, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[3] = '{1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'hA5};
        vecs[4] = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[5] = '{1'b1, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[6] = '{1'b0, 8'h5A, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 8'h5A};
        vecs[8] = '{1'b1, 8'h5A, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 8'h00};
        vecs[9] = '{1'b1, 8'h00, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 8'h00};

        rst = 1'b1;
        RxD_data = 8'h00;
        RDA = 1'b1;
        rd_en = 1'b0;
        clr_ovr = 1'b0;
        #2;
        chk("reset count", 32'(count), 32'd0);
        chk("reset empty", 32'(empty), 32'd1);
        chk("reset rd_data", 32'(rd_data), 32'h00);
        do_reset();

        for (int i = 0; i < 20; i++) tick();
        chk("idle count", 32'(count), 32'd0);
        chk("idle empty", 32'(empty), 32'd1);
        chk("idle rd_data", 32'(rd_data), 32'h00);

        for (int i = 0; i < 10; i++) begin
            RDA = vecs[i].rda;
            RxD_data = vecs[i].data;
            rd_en = vecs[i].rd;
            clr_ovr = vecs[i].clr;
            tick();
            chk($sformatf("v%0d count", i), 32'(count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d empty", i), 32'(empty), 32'(vecs[i].e_emp));
            chk($sformatf("v%0d full", i), 32'(full), 32'(vecs[i].e_full));
            chk($sformatf("v%0d ovr", i), 32'(overrun), 32'(vecs[i].e_ovr));
            chk($sformatf("v%0d rd", i), 32'(rd_data), 32'(vecs[i].e_rd));
        end
        rd_en = 1'b0;
        clr_ovr = 1'b0;

        do_reset();
        push_byte(8'hA5, 1'b0, 1'b0, 10);
        pop_byte(8'hA5);

        for (int i = 1; i <= 8; i++) push_byte(8'(i), 1'b0, 1'b0, 2);
        chk("fill full", 32'(full), 32'd1);
        push_byte(8'h09, 1'b0, 1'b0, 2);
        chk("ovr set", 32'(overrun), 32'd1);
        push_byte(8'h0A, 1'b0, 1'b1, 2);
        chk("ovr set wins", 32'(overrun), 32'd1);
        for (int i = 1; i <= 8; i++) pop_byte(8'(i));
        chk("drained", 32'(empty), 32'd1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        m_ovr = 1'b0;
        check_model("clr");

        for (int i = 0; i < 5; i++) push_byte(8'h40 + 8'(i), 1'b0, 1'b0, 2);
        for (int i = 0; i < 5; i++) pop_byte(8'h40 + 8'(i));
        for (int i = 0; i < 6; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0, 2);
        for (int i = 0; i < 6; i++) pop_byte(8'h10 + 8'(i));
        chk("wrap empty", 32'(count), 32'd0);

        for (int i = 0; i < 8; i++) push_byte(8'h20 + 8'(i), 1'b0, 1'b0, 2);
        push_byte(8'hEE, 1'b1, 1'b0, 2);
        chk("simul count", 32'(count), 32'd8);
        chk("simul ovr", 32'(overrun), 32'd0);
        for (int i = 1; i < 8; i++) pop_byte(8'h20 + 8'(i));
        pop_byte(8'hEE);

        for (int i = 0; i < 3; i++) push_byte(8'h70 + 8'(i), 1'b0, 1'b0, 2);
        push_byte(8'h7F, 1'b1, 1'b0, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("async rst count", 32'(count), 32'd0);
        chk("async rst empty", 32'(empty), 32'd1);
        chk("async rst ovr", 32'(overrun), 32'd0);
        tick();
        rst = 1'b0;
        sb.delete();
        m_cnt = 0;
        m_ovr = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_model("post rst idle");
        push_byte(8'h3C, 1'b0, 1'b0, 4);
        chk("post rst data", 32'(rd_data), 32'h3C);
        pop_byte(8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
